// File: rtl/dlf_pkg.sv
// Shared DLFloat16 constants, exception flag indices and converter FSM states.
// DLFloat16 layout: {sign[15], exp[14:9] biased by 31, mant[8:0]}, no subnormals.
package dlf_pkg;

  localparam int DLF_EXP_W  = 6;
  localparam int DLF_MANT_W = 9;
  localparam int DLF_BIAS   = 31;

  localparam int EXC_INVALID   = 4;
  localparam int EXC_OVERFLOW  = 3;
  localparam int EXC_DIV_ZERO  = 2;
  localparam int EXC_UNDERFLOW = 1;
  localparam int EXC_INEXACT   = 0;

  localparam logic [15:0] DLF_NAN_POS = 16'h7FFF;
  localparam logic [15:0] DLF_NAN_NEG = 16'hFFFF;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    SHIFT,
    PACK,
    DONE
  } f2i_state_t;

  function automatic logic [4:0] exc_bit(input int idx);
    return 5'b1 << idx;
  endfunction

endpackage

// File: rtl/dlf16_classify.sv
// Combinational decode of a DLFloat16 operand into sign, zero, NaN/Inf,
// unbiased exponent (two's complement, -31..32) and mantissa.
module dlf16_classify (
  input  logic [15:0] in_float,
  output logic        sign,
  output logic        zero,
  output logic        nan,
  output logic [6:0]  exp_unb,
  output logic [8:0]  mant
);
  import dlf_pkg::*;

  logic [DLF_EXP_W-1:0] exp_b;

  assign sign    = in_float[15];
  assign exp_b   = in_float[14:9];
  assign mant    = in_float[8:0];
  assign zero    = (exp_b == '0);
  // Single NaN/Inf encoding per sign; other exp=63 codes are just large numbers.
  assign nan     = (in_float[14:0] == DLF_NAN_POS[14:0]);
  assign exp_unb = {1'b0, exp_b} - 7'(DLF_BIAS);

endmodule

// File: rtl/fp_float2int.sv
// DLFloat16 -> signed int32 converter using a bounded per-cycle left shifter.
// Optional macro FP_FLOAT2INT_RNE_EN selects round-to-nearest-even instead of truncation.
//
// state  | meaning
// IDLE   | waiting for an operand, in_ready high
// DECODE | classify operand; specials resolve straight to DONE
// SHIFT  | shift accumulator left by up to SHIFT_STEP per cycle
// PACK   | extract integer/fraction, round, apply sign
// DONE   | result held until out_ready
module fp_float2int #(
  parameter int SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_float,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] int_out,
  output logic [4:0]  exceptions
);
  import dlf_pkg::*;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  f2i_state_t  state;
  logic [15:0] op_q;
  logic [39:0] acc;
  logic [4:0]  remaining;

  logic        op_sign;
  logic        op_zero;
  logic        op_nan;
  logic [6:0]  op_exp_unb;
  logic [8:0]  op_mant;
  logic signed [6:0] e_unb;

  dlf16_classify u_classify (
    .in_float (op_q),
    .sign     (op_sign),
    .zero     (op_zero),
    .nan      (op_nan),
    .exp_unb  (op_exp_unb),
    .mant     (op_mant)
  );

  assign e_unb = op_exp_unb;

  logic [4:0]  step_amt;
  logic [30:0] mag_trunc;
  logic [8:0]  frac;
  logic        round_up;
  logic [31:0] mag;
  logic [31:0] pack_result;

  assign step_amt  = (remaining > STEP) ? STEP : remaining;
  assign mag_trunc = acc[39:9];
  assign frac      = acc[8:0];

`ifdef FP_FLOAT2INT_RNE_EN
  assign round_up = frac[8] & ((|frac[7:0]) | mag_trunc[0]);
`else
  assign round_up = 1'b0;
`endif

  // Rounding only occurs for E < 9, so the increment can never reach 2^31.
  assign mag         = {1'b0, mag_trunc} + {31'd0, round_up};
  assign pack_result = op_sign ? (~mag + 32'd1) : mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      acc        <= '0;
      remaining  <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      int_out    <= '0;
      exceptions <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= in_float;
            in_ready <= 1'b0;
            state    <= DECODE;
          end
        end

        DECODE: begin
          state <= DONE;
          if (op_zero) begin
            int_out    <= '0;
            exceptions <= '0;
            out_valid  <= 1'b1;
          end else if (op_nan) begin
            int_out    <= op_sign ? INT32_MIN : INT32_MAX;
            exceptions <= exc_bit(EXC_INVALID);
            out_valid  <= 1'b1;
          end else if ((e_unb > 7'sd31) ||
                       ((e_unb == 7'sd31) && !(op_sign && (op_mant == '0)))) begin
            int_out    <= op_sign ? INT32_MIN : INT32_MAX;
            exceptions <= exc_bit(EXC_OVERFLOW);
            out_valid  <= 1'b1;
          end else if (e_unb == 7'sd31) begin
            int_out    <= INT32_MIN;
            exceptions <= '0;
            out_valid  <= 1'b1;
          end else if (e_unb[6]) begin
            out_valid <= 1'b1;
`ifdef FP_FLOAT2INT_RNE_EN
            // Magnitude in [0.5, 1): rounds to 1 unless it is exactly the 0.5 tie.
            if ((e_unb == -7'sd1) && (op_mant != '0)) begin
              int_out    <= op_sign ? 32'hFFFF_FFFF : 32'd1;
              exceptions <= exc_bit(EXC_INEXACT);
            end else begin
              int_out    <= '0;
              exceptions <= exc_bit(EXC_UNDERFLOW) | exc_bit(EXC_INEXACT);
            end
`else
            int_out    <= '0;
            exceptions <= exc_bit(EXC_UNDERFLOW) | exc_bit(EXC_INEXACT);
`endif
          end else begin
            acc       <= {30'd0, 1'b1, op_mant};
            remaining <= e_unb[4:0];
            state     <= (e_unb == 7'sd0) ? PACK : SHIFT;
          end
        end

        SHIFT: begin
          acc       <= acc << step_amt;
          remaining <= remaining - step_amt;
          if (remaining == step_amt)
            state <= PACK;
        end

        PACK: begin
          int_out    <= pack_result;
          exceptions <= (|frac) ? exc_bit(EXC_INEXACT) : 5'b0;
          out_valid  <= 1'b1;
          state      <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_float2int.sv
// Directed-vector bench for fp_float2int with SHIFT_STEP = 8.
// Expectations follow FP_FLOAT2INT_RNE_EN when the macro is defined.
module tb_fp_float2int;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_float = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] int_out;
  logic [4:0]  exceptions;

  int n_checks = 0;
  int n_errors = 0;

  fp_float2int #(.SHIFT_STEP(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_float   (in_float),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .int_out    (int_out),
    .exceptions (exceptions)
  );

  always #5 clk = ~clk;

`ifdef FP_FLOAT2INT_RNE_EN
  localparam logic [31:0] R_0P75  = 32'h0000_0001;
  localparam logic [4:0]  X_0P75  = 5'b00001;
  localparam logic [31:0] R_M0P75 = 32'hFFFF_FFFF;
  localparam logic [4:0]  X_M0P75 = 5'b00001;
  localparam logic [31:0] R_3P5   = 32'h0000_0004;
`else
  localparam logic [31:0] R_0P75  = 32'h0000_0000;
  localparam logic [4:0]  X_0P75  = 5'b00011;
  localparam logic [31:0] R_M0P75 = 32'h0000_0000;
  localparam logic [4:0]  X_M0P75 = 5'b00011;
  localparam logic [31:0] R_3P5   = 32'h0000_0003;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] f);
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    check_val("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_float = f;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic take_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_val({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [15:0] f, input logic [31:0] ei,
                     input logic [4:0] ee, input int el);
    int lat;
    send(f);
    wait_out(lat);
    check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_val({tag, "_int"}, int_out, ei);
    check_val({tag, "_exc"}, {27'd0, exceptions}, {27'd0, ee});
    check_val({tag, "_lat"}, lat, el);
    take_out(tag);
  endtask

  initial begin
    int lat;
    #12;
    check_val("rst_int", int_out, 32'd0);
    check_val("rst_exc", {27'd0, exceptions}, 32'd0);
    check_val("rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    run("one",      16'h3E00, 32'h0000_0001, 5'b00000, 2);
    run("mone",     16'hBE00, 32'hFFFF_FFFF, 5'b00000, 2);

    // Long shift with backpressure: outputs must hold while out_ready is low.
    send(16'h7A01);
    wait_out(lat);
    check_val("big_int", int_out, 32'h4020_0000);
    check_val("big_exc", {27'd0, exceptions}, 32'd0);
    check_val("big_lat", lat, 6);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_val("hold_valid", {31'd0, out_valid}, 32'd1);
      check_val("hold_int", int_out, 32'h4020_0000);
      check_val("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    take_out("big");

    run("negbig",   16'hFA01, 32'hBFE0_0000, 5'b00000, 6);
    run("e16",      16'h5E00, 32'h0001_0000, 5'b00000, 4);
    run("e8",       16'h4E00, 32'h0000_0100, 5'b00000, 3);
    run("e8half",   16'h4E01, 32'h0000_0100, 5'b00001, 3);
    run("exactmin", 16'hFC00, 32'h8000_0000, 5'b00000, 1);
    run("ovf_pos",  16'h7E00, 32'h7FFF_FFFF, 5'b01000, 1);
    run("ovf_e31",  16'h7C00, 32'h7FFF_FFFF, 5'b01000, 1);
    run("ovf_neg",  16'hFC01, 32'h8000_0000, 5'b01000, 1);
    run("ovf_e32",  16'h7F00, 32'h7FFF_FFFF, 5'b01000, 1);
    run("nan_pos",  16'h7FFF, 32'h7FFF_FFFF, 5'b10000, 1);
    run("nan_neg",  16'hFFFF, 32'h8000_0000, 5'b10000, 1);
    run("zero",     16'h0000, 32'h0000_0000, 5'b00000, 1);
    run("zero_m",   16'h8123, 32'h0000_0000, 5'b00000, 1);
    run("p2p5",     16'h4080, 32'h0000_0002, 5'b00001, 3);
    run("m2p5",     16'hC080, 32'hFFFF_FFFE, 5'b00001, 3);
    run("p3p5",     16'h4180, R_3P5,         5'b00001, 3);
    run("p0p75",    16'h3D00, R_0P75,        X_0P75,   1);
    run("m0p75",    16'hBD00, R_M0P75,       X_M0P75,  1);
    run("p0p5",     16'h3C00, 32'h0000_0000, 5'b00011, 1);
    run("p0p25",    16'h3A00, 32'h0000_0000, 5'b00011, 1);

    // Reset in the middle of SHIFT discards the operand immediately.
    send(16'h7A01);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("mid_rst_int", int_out, 32'd0);
    check_val("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run("after_rst", 16'h3E00, 32'h0000_0001, 5'b00000, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_float2int.md
Name: fp_float2int

Overview:
- Converts a DLFloat16 value to a signed 32-bit integer. This is the inverse of the existing int-to-float converter in the DL FPU.
- DLFloat16 layout: {sign[15], exp[14:9] biased by 31, mant[8:0]}. There are no subnormals.
- Uses a multi-cycle FSM with a bounded per-cycle left shifter, so it fits the FPU's slow-path timing budget.
- Valid/ready handshake on both the input and the output.

Parameters:
- SHIFT_STEP, 8: maximum left-shift distance per SHIFT cycle; legal range 1..30.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  float operand valid
- in_ready  output  1  block can accept an operand
- in_float  input  16  DLFloat16 operand
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- int_out  output  32  signed two's-complement result
- exceptions  output  5  flags: [4] invalid, [3] overflow, [2] div-by-zero (always 0), [1] underflow, [0] inexact

Behaviour:
- Reset (asynchronous, any state, including mid-conversion):
  - state = IDLE; int_out = 0, exceptions = 0, out_valid = 0, in_ready = 1.
  - Any in-flight operand is discarded.
- Decode: E = exp − 31.
  - Zero: exp = 0, regardless of mantissa.
  - NaN/Inf: exp = 63 and mant = 511.
- IDLE:
  - in_ready = 1.
  - When in_valid is high, capture in_float and go to DECODE.
- DECODE (one cycle); the result class is chosen here:
  - Zero → result 0, flags 0.
  - NaN/Inf → result 0x7FFFFFFF if sign = 0, else 0x80000000; invalid set.
  - E > 31, or E = 31 other than exact −2^31 (sign = 1, mant = 0) → saturate to 0x7FFFFFFF or 0x80000000 by sign; overflow set.
  - Exact −2^31 → 0x80000000, no flags.
  - E < 0 → result 0; underflow and inexact set.
  - Each of the cases above goes straight to DONE.
  - 0 ≤ E ≤ 30 → load the 40-bit accumulator with {1, mant} in bits [9:0], set remaining = E, go to SHIFT (or to PACK if E = 0).
- SHIFT:
  - Each cycle, shift the accumulator left by min(SHIFT_STEP, remaining) and decrement remaining by that amount.
  - When remaining reaches 0, go to PACK.
- PACK:
  - magnitude = acc[39:9]; frac = acc[8:0].
  - inexact = OR of frac.
  - Result = magnitude negated when sign = 1. Positive zero when magnitude is 0.
  - Go to DONE.
- DONE:
  - out_valid = 1; int_out and exceptions are held stable until out_ready is sampled high.
  - Then go to IDLE.
- in_ready = (state == IDLE). A new operand is never accepted in the same cycle as an output handshake.
- Latency, counted in edges from the accepting edge until out_valid is visible:
  - 1 for special cases.
  - 2 + ceil(E / SHIFT_STEP) for the normal path.
- int_out and exceptions are registered and change only when entering DONE or on reset.

Optional Feature:
- Macro: FP_FLOAT2INT_RNE_EN.
- Defined: round-to-nearest-even in PACK.
  - guard = frac[8]; sticky = OR of frac[7:0].
  - Increment magnitude when guard & (sticky | magnitude[0]).
  - E = −1: result ±1 if mant ≠ 0, else 0 (tie to even). Inexact is always set; underflow is set only when the result is 0.
  - E < −1: behaves as without the macro.
- Not defined: truncation toward zero, as described in Behaviour.

Decomposition:
- Shared package dlf_pkg:
  - DLF_EXP_W = 6, DLF_MANT_W = 9, DLF_BIAS = 31.
  - Exception bit index constants.
  - FSM state typedef: IDLE, DECODE, SHIFT, PACK, DONE.
  - NaN encoding constant 0x7FFF/0xFFFF.
- Sub-module dlf16_classify: combinational decode of the operand into {zero, nan, E, mant}, reusable by other FPU blocks.

Test Plan:
- 0x3E00 (1.0) → int_out 0x00000001, exceptions 00000, out_valid 2 edges after accept.
- 0x7A01 (2^30 + 2^21), SHIFT_STEP = 8 → 0x40200000, exceptions 00000, latency 6; hold out_ready low 3 cycles → outputs stable, in_ready 0.
- 0xFC00 → 0x80000000, flags 00000; 0x7E00 → 0x7FFFFFFF, 01000; 0x7FFF → 0x7FFFFFFF, 10000; 0xFFFF → 0x80000000, 10000.
- 0x4080 (2.5) → 0x00000002, 00001; 0xC080 (−2.5) → 0xFFFFFFFE, 00001. The same results are required with FP_FLOAT2INT_RNE_EN (ties to even).
- 0x3D00 (0.75) → 0, 00011; with FP_FLOAT2INT_RNE_EN → 0x00000001, 00001.
- Assert rst during SHIFT of 0x7A01 → out_valid 0, int_out 0, in_ready 1 immediately; next operand 0x3E00 converts normally.
